jk_bank_arbiter: RTL and testbench

//  Shares one bank of NBITS JK flip-flops between NREQ requesters. Each requester issues
//  one command per handshake: bit address plus J/K, meaning hold/reset/set/toggle.
//  A round-robin FSM grants one requester at a time, applies the JK update to the addressed
//  bit, then acknowledges the requester. Sits between requester logic and the JK state bank.

---
 rtl/jk_bank_arbiter.sv | 113 +++++++++++
 tb/tb_jk_bank_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of JK flip-flops between NREQ requesters.
// Each granted command is applied in APPLY and acknowledged for one cycle in ACK.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = (NBITS > 1) ? $clog2(NBITS) : 1,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_all,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ-1:0]    req_j,
    input  logic [NREQ-1:0]    req_k,
    output logic [NREQ-1:0]    req_ready,
    output logic [NBITS-1:0]   q,
    output logic               busy,
    output logic [GW-1:0]      grant_id,
    output logic               addr_err
);

    typedef enum logic [1:0] {IDLE, APPLY, ACK} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          j;
        logic          k;
    } cmd_t;

    state_t          state;
    cmd_t            cmd;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   win;
    logic            found;
    int              idx;
    logic [NBITS-1:0] q_nxt;
    logic            oor;

    // Search starts one past the last winner so the last winner ends up lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    // An address that matches no bit leaves q alone and is flagged as out of range.
    always_comb begin
        q_nxt = q;
        oor   = 1'b1;
        for (int b = 0; b < NBITS; b++) begin
            if (cmd.addr == AW'(b)) begin
                oor = 1'b0;
                case ({cmd.j, cmd.k})
                    2'b01:   q_nxt[b] = 1'b0;
                    2'b10:   q_nxt[b] = 1'b1;
                    2'b11:   q_nxt[b] = ~q[b];
                    default: q_nxt[b] = q[b];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cmd       <= '0;
            rr_ptr    <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
            req_ready <= '0;
            addr_err  <= 1'b0;
            q         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id <= win;
                        cmd.addr <= req_addr[int'(win)*AW +: AW];
                        cmd.j    <= req_j[win];
                        cmd.k    <= req_k[win];
                        busy     <= 1'b1;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    q         <= q_nxt;
                    addr_err  <= oor;
                    req_ready <= NREQ'(1) << grant_id;
                    state     <= ACK;
                end
                ACK: begin
                    req_ready <= '0;
                    addr_err  <= 1'b0;
                    busy      <= 1'b0;
                    rr_ptr    <= grant_id;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Clear wins over a same-edge APPLY; the command is still acknowledged.
            if (clr_all) q <= '0;
        end
    end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus randomized requesters,
// all checked every cycle against a transaction-level model of the bank.
module tb_jk_bank_arbiter;
    localparam int NR = 4;
    localparam int NB = 6;
    localparam int AW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clr_all = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR-1:0]  req_j = '0;
    logic [NR-1:0]  req_k = '0;
    logic [NR-1:0]  req_ready;
    logic [NB-1:0]  q;
    logic           busy;
    logic [1:0]     grant_id;
    logic           addr_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    jk_bank_arbiter #(.NREQ(NR), .NBITS(NB)) dut (
        .clk(clk), .rst(rst), .clr_all(clr_all), .req_valid(req_valid),
        .req_addr(req_addr), .req_j(req_j), .req_k(req_k), .req_ready(req_ready),
        .q(q), .busy(busy), .grant_id(grant_id), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a command is taken when the bank is free, lands one cycle later,
    // is acknowledged the cycle after that, and the bank is free again after the ack.
    logic [NB-1:0] m_q = '0;
    logic [NR-1:0] m_ready = '0;
    logic          m_busy = 0, m_err = 0;
    logic [1:0]    m_gid = '0;
    int            m_rr = 0, m_phase = 0, m_addr = 0, m_w;
    bit            m_j, m_k;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q = '0; m_ready = '0; m_busy = 0; m_err = 0; m_gid = '0;
            m_rr = 0; m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                m_w = -1;
                for (int k = 1; k <= NR; k++)
                    if (m_w < 0 && req_valid[(m_rr + k) % NR]) m_w = (m_rr + k) % NR;
                if (m_w >= 0) begin
                    m_gid = 2'(m_w);
                    m_addr = int'(req_addr[m_w*AW +: AW]);
                    m_j = req_j[m_w]; m_k = req_k[m_w];
                    m_busy = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_addr < NB) begin
                    if (m_j && m_k) m_q[m_addr] = ~m_q[m_addr];
                    else if (m_j)   m_q[m_addr] = 1'b1;
                    else if (m_k)   m_q[m_addr] = 1'b0;
                end else m_err = 1;
                m_ready = '0;
                m_ready[m_gid] = 1'b1;
                m_phase = 2;
            end else begin
                m_ready = '0; m_err = 0; m_busy = 0; m_rr = int'(m_gid); m_phase = 0;
            end
            if (clr_all) m_q = '0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", req_ready, m_ready);
            chk("q", q, m_q);
            chk("busy", busy, m_busy);
            chk("grant_id", grant_id, m_gid);
            chk("addr_err", addr_err, m_err);
            chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_valid = '0; clr_all = 0;
        rst = 0; tick(); tick(); rst = 1;
    endtask

    task automatic set_req(input int r, input int a, input bit j, input bit k);
        req_valid[r] = 1'b1;
        req_addr[r*AW +: AW] = 3'(a);
        req_j[r] = j; req_k[r] = k;
    endtask

    task automatic send(input int r, input int a, input bit j, input bit k,
                        output bit err, output int at);
        set_req(r, a, j, k);
        err = 0; at = -1;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (req_ready[r]) begin err = addr_err; at = cyc; break; end
        end
        if (at < 0) chk("send_timeout", 0, 1);
        req_valid[r] = 1'b0;
    endtask

    logic [1:0] jk_seq [4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    logic [NB-1:0] q_exp [4] = '{6'h08, 6'h08, 6'h00, 6'h00};

    initial begin
        bit e; int at, prev, got;
        #1 rst = 0;
        tick(); tick(); rst = 1;
        cmp_en = 1;
        chk("reset_q", q, 0);
        chk("reset_busy", busy, 0);

        // JK truth table on bit 3 and 3-cycle acknowledge spacing
        do_reset();
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(0, 3, jk_seq[i][1], jk_seq[i][0], e, at);
            chk("jk_q", q, q_exp[i]);
            if (i > 0) chk("ready_spacing", at - prev, 3);
            prev = at;
        end

        // Round robin from reset with everyone asserting
        do_reset();
        for (int r = 0; r < NR; r++) set_req(r, 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            got = -1;
            for (int t = 0; t < 10 && got < 0; t++) begin
                tick();
                for (int r = 0; r < NR; r++) if (req_ready[r]) got = r;
            end
            chk("rr_order", got, (n + 1) % NR);
        end
        req_valid = '0; tick(); tick();

        // Out-of-range addresses
        do_reset();
        send(2, 7, 1, 0, e, at);
        chk("oor_err", e, 1);
        chk("oor_q", q, 0);
        send(2, 5, 1, 0, e, at);
        chk("inrange_err", e, 0);
        chk("inrange_q", q, 6'h20);

        // clr_all on the APPLY edge
        do_reset();
        for (int b = 0; b < 4; b++) send(0, b, 1, 0, e, at);
        chk("pre_clr_q", q, 6'h0F);
        tick();
        set_req(1, 5, 1, 0);
        tick();
        chk("clr_busy", busy, 1);
        clr_all = 1;
        tick();
        clr_all = 0;
        chk("clr_q", q, 0);
        chk("clr_ready", req_ready, 4'b0010);
        req_valid = '0; tick(); tick();

        // Valid dropped right after grant
        do_reset();
        set_req(3, 2, 1, 0);
        tick();
        req_valid[3] = 0;
        tick();
        chk("drop_ready", req_ready, 4'b1000);
        chk("drop_q", q, 6'h04);
        tick(); tick();
        chk("drop_idle_busy", busy, 0);
        chk("drop_gid", grant_id, 3);

        // Async reset in the middle of APPLY
        do_reset();
        for (int b = 0; b < NB; b++) send(0, b, 1, 0, e, at);
        chk("pre_rst_q", q, 6'h3F);
        tick();
        set_req(0, 0, 1, 1);
        tick();
        rst = 0;
        #1;
        chk("async_q", q, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", req_ready, 0);
        req_valid = '0;
        tick(); rst = 1;

        // Randomized requesters obeying the handshake
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (req_valid[r] && req_ready[r]) begin
                    if ($urandom_range(1, 0)) set_req(r, $urandom_range(7, 0), 1'($urandom), 1'($urandom));
                    else req_valid[r] = 0;
                end else if (!req_valid[r]) begin
                    if ($urandom_range(3, 0) == 0) set_req(r, $urandom_range(7, 0), 1'($urandom), 1'($urandom));
                end else if (busy && grant_id == 2'(r) && $urandom_range(7, 0) == 0) begin
                    req_valid[r] = 0;
                end
            end
            clr_all = ($urandom_range(31, 0) == 0);
            if ($urandom_range(599, 0) == 0) begin
                rst = 0; tick(); rst = 1;
            end else tick();
        end
        clr_all = 0; req_valid = '0;
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
